hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameter DATA_W, default 32: width of operands and of each of HI and LO; legal values are 8, 16, 32 and 64.
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1: width of the iteration counter.
REQ-003 clk  input  1  Single clock for all state.
REQ-004 rst  input  1  Reset, synchronous and active-low; asserted when rst==0.
REQ-005 start_i  input  1  Request strobe, qualified with op_i.
REQ-006 op_i  input  3  Operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a_i  input  DATA_W  Operand A: multiplicand, dividend, or MTHI/MTLO data.
REQ-008 b_i  input  DATA_W  Operand B: multiplier or divisor.
REQ-009 cancel_i  input  1  Pipeline flush; aborts an operation in flight.
REQ-010 busy_o  output  1  An iterative operation is in progress; the core stalls on this.
REQ-011 done_o  output  1  One-cycle pulse: HI/LO were updated by MULT/DIV on the previous edge.
REQ-012 hi_o  output  DATA_W  Architectural HI.
REQ-013 lo_o  output  DATA_W  Architectural LO.

Function
REQ-014 FSM states: IDLE, CALC, FIN.
REQ-015 IDLE or FIN with start_i=1 and a MULT/DIV-class op: latch the operands, load the counter with DATA_W, and go to CALC.
REQ-016 CALC performs one radix-2 step per cycle (shift-add for multiply, restoring for divide) and decrements the counter.
REQ-017 When the counter reaches 1 in CALC, the next edge writes HI/LO and moves to FIN, so done_o=1 is seen DATA_W+1 cycles after start.
REQ-018 FIN lasts one cycle, then goes to IDLE unless a new start is accepted.
REQ-019 busy_o=1 exactly while in CALC; done_o=1 exactly while in FIN.
REQ-020 MTHI/MTLO with start_i=1 in IDLE or FIN: the next edge writes a_i to HI or LO respectively, and the other register holds.
REQ-021 MTHI/MTLO never enters CALC and never pulses done_o.
REQ-022 start_i in CALC is ignored for all ops; the issuer holds the request until busy_o=0.
REQ-023 Multiply result: HI is the upper DATA_W bits and LO the lower DATA_W bits of the 2*DATA_W-bit product.
REQ-024 MULT treats operands as two's complement; MULTU treats them as unsigned.
REQ-025 Divide result: LO=quotient, HI=remainder.
REQ-026 Signed divide: compute on magnitudes; quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
REQ-027 Divide by zero (b_i==0), signed or unsigned: HI=a_i, LO=all ones, with the normal latency.
REQ-028 Signed overflow (most-negative / -1): LO=most-negative, HI=0.
REQ-029 cancel_i=1 in CALC: return to IDLE on the next edge; HI/LO unchanged; no done_o.
REQ-030 cancel_i=1 together with an accepted start: the start is dropped.
REQ-031 cancel_i=1 in FIN: no effect, since HI/LO are already committed.
REQ-032 Illegal op_i codes with start_i=1: no-op, no state change.
REQ-033 hi_o/lo_o change only on commit edges (REQ-017, REQ-020); they are constant at all other times, including during CALC.

Reset
REQ-034 rst==0 at a clk edge forces state to IDLE, counter to 0, and hi_o, lo_o, busy_o, done_o to 0.
REQ-035 Reset takes priority over start_i and cancel_i; reset mid-CALC discards the operation.
REQ-036 No output has an asynchronous path from rst.

Structure
REQ-037 Shared package hilo_pkg holds the op_i encodings, the FSM state enum, and the divide-by-zero LO constant rule.
REQ-038 The iterative shift/add/subtract datapath (accumulator, operand registers, sign fix-up) lives in sub-module hilo_mdu_core.
REQ-039 hilo_mdu owns the FSM, the counter, the cancel logic and the HI/LO registers.

Verification (DATA_W=32)
REQ-040 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o at cycle 33 after start; busy_o high for exactly 32 cycles.
REQ-041 DIV a=-7 (0xFFFFFFF9) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100 b=0 -> HI=100, LO=0xFFFFFFFF.
REQ-042 MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi_o/lo_o updated one edge after each request; busy_o and done_o stay 0.
REQ-043 MULT 3*5, then cancel_i at cycle 10 -> state IDLE, HI/LO keep their prior values, no done_o; a subsequent MULT completes normally.
REQ-044 rst=0 at cycle 20 of a DIV -> all outputs 0 next cycle; a start issued during CALC is ignored, and a start issued in FIN is accepted back-to-back.
REQ-045 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; sweep DATA_W=8 against a random reference model.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings, FSM states and divide-by-zero result for the HI/LO unit
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Divide by zero returns all ones in LO at every legal width; users slice to DATA_W.
  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/hilo_mdu_core.sv
// rtl/hilo_mdu_core.sv - radix-2 shift-add multiply / restoring divide datapath with sign fix-up
module hilo_mdu_core
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  logic [DATA_W-1:0] acc_q, q_q, m_q, a_q;
  logic              div_q, neg_q, neg_r_q, dz_q;

  logic              is_div, is_sgn, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = is_sgn & a[DATA_W-1];
  assign b_neg  = is_sgn & b[DATA_W-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // acc holds the running upper half (multiply) or partial remainder (divide);
  // q holds the multiplier bits being consumed or the quotient bits being produced.
  logic [DATA_W:0]     sum, part, trial;
  logic                ge;
  logic [DATA_W-1:0]   acc_n, q_n;
  logic [2*DATA_W-1:0] prod, prod_fix;

  assign sum   = q_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {1'b0, acc_q};
  assign part  = {acc_q, q_q[DATA_W-1]};
  assign trial = part - {1'b0, m_q};
  assign ge    = ~trial[DATA_W];
  assign acc_n = div_q ? (ge ? trial[DATA_W-1:0] : part[DATA_W-1:0]) : sum[DATA_W:1];
  assign q_n   = div_q ? {q_q[DATA_W-2:0], ge} : {sum[0], q_q[DATA_W-1:1]};

  assign prod     = {acc_n, q_n};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
    if (div_q) begin
      if (dz_q) begin
        res_hi = a_q;
        res_lo = DIV_ZERO_LO[DATA_W-1:0];
      end else begin
        res_hi = neg_r_q ? -acc_n : acc_n;
        res_lo = neg_q ? -q_n : q_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (load) begin
      acc_q   <= '0;
      q_q     <= is_div ? a_mag : b_mag;
      m_q     <= is_div ? b_mag : a_mag;
      a_q     <= a;
      div_q   <= is_div;
      neg_q   <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      dz_q    <= is_div && (b == '0);
    end else if (step) begin
      acc_q <= acc_n;
      q_q   <= q_n;
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO multiply-divide unit: FSM, iteration counter, cancel and architectural HI/LO
module hilo_mdu
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DATA_W-1:0] hi_q, lo_q, core_hi, core_lo;
  logic              load, step, commit, mt_hi, mt_lo, accept, is_iter;

  assign is_iter = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                   (op_i == OP_DIV)  || (op_i == OP_DIVU);
  // A flush in the same cycle as a request kills the request.
  assign accept  = start_i && !cancel_i && (state_q != ST_CALC);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state_q)
      ST_CALC: begin
        if (cancel_i) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          step  = 1'b1;
          cnt_n = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            commit  = 1'b1;
            state_n = ST_FIN;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        if (accept && is_iter) begin
          load    = 1'b1;
          state_n = ST_CALC;
          cnt_n   = CNT_W'(DATA_W);
        end
        mt_hi = accept && (op_i == OP_MTHI);
        mt_lo = accept && (op_i == OP_MTLO);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (commit) begin
        hi_q <= core_hi;
        lo_q <= core_lo;
      end
      if (mt_hi) hi_q <= a_i;
      if (mt_lo) lo_q <= a_i;
    end
  end

  hilo_mdu_core #(.DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  assign busy_o = (state_q == ST_CALC);
  assign done_o = (state_q == ST_FIN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - directed bench for hilo_mdu at DATA_W=32 plus an 8-bit reference sweep
module tb_hilo_mdu;
  import hilo_pkg::*;

  logic        clk, rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  logic        start8, cancel8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8;

  int checks = 0;
  int failures = 0;

  hilo_mdu #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  hilo_mdu #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .cancel_i(cancel8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       output int cyc, output int bcnt);
    start = 1'b1; op = o; a = va; b = vb;
    tick();
    start = 1'b0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5; cancel = 1'b0;
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'd3; b8 = 8'd5; cancel8 = 1'b0;
    tick(); tick();
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy8 !== 1'b0 || hi8 !== 8'h0) begin failures++; $display("FAIL reset_8 busy=%b hi=%h exp=0", busy8, hi8); end
    start = 1'b0; start8 = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_multu();
    int cyc, bc;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bc);
    checks++; if (cyc != 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
    checks++; if (bc != 32) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=32", bc); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL fin_one_cycle done=%b exp=0", done); end
  endtask

  task automatic test_mult_signed();
    int cyc, bc;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, cyc, bc);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
    issue(OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, cyc, bc);
    checks++; if (hi !== 32'h0 || lo !== 32'd24) begin
      failures++; $display("FAIL mult_negneg got=%h_%h exp=00000000_00000018", hi, lo); end
  endtask

  task automatic test_div();
    logic [2:0]  vo[6] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] va[6] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'd7};
    logic [31:0] vb[6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd7, 32'hFFFFFFFE};
    logic [31:0] eh[6] = '{32'hFFFFFFFF, 32'd100, 32'h0, 32'hFFFFFFF9, 32'd2, 32'd1};
    logic [31:0] el[6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd14, 32'hFFFFFFFD};
    int cyc, bc;
    for (int i = 0; i < 6; i++) begin
      issue(vo[i], va[i], vb[i], cyc, bc);
      checks++; if (cyc != 33 || hi !== eh[i] || lo !== el[i]) begin
        failures++;
        $display("FAIL div_vec%0d got cyc=%0d hi=%h lo=%h exp cyc=33 hi=%h lo=%h", i, cyc, hi, lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_mt();
    tick();
    start = 1'b1; op = OP_MTHI; a = 32'h12345678;
    tick();
    checks++; if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL mthi got=%h_%h exp=12345678_fffffffd", hi, lo); end
    op = OP_MTLO; a = 32'h9ABCDEF0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi_flags busy=%b done=%b exp=0,0", busy, done); end
    tick();
    checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      failures++; $display("FAIL mtlo got=%h_%h exp=12345678_9abcdef0", hi, lo); end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mt_flags busy=%b done=%b exp=0,0", busy, done); end
  endtask

  task automatic test_cancel();
    int cyc, bc;
    bit saw;
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL cancel_state busy=%b done=%b exp=0,0", busy, done); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      failures++; $display("FAIL cancel_hold got=%h_%h exp=12345678_9abcdef0", hi, lo); end
    saw = 1'b0;
    repeat (40) begin tick(); if (done) saw = 1'b1; end
    checks++; if (saw) begin failures++; $display("FAIL cancel_no_done saw_done=1 exp=0"); end
    start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_drops_start busy=%b exp=0", busy); end
    issue(OP_MULT, 32'd3, 32'd5, cyc, bc);
    checks++; if (cyc != 33 || hi !== 32'h0 || lo !== 32'd15) begin
      failures++; $display("FAIL mult_after_cancel cyc=%0d got=%h_%h exp=33 00000000_0000000f", cyc, hi, lo); end
  endtask

  task automatic test_illegal();
    tick();
    start = 1'b1; op = 3'd6; a = 32'hFFFF; b = 32'd1;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'd15) begin
      failures++; $display("FAIL illegal_op busy=%b done=%b hi=%h lo=%h exp=0,0,0,f", busy, done, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit saw;
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_calc hi=%h lo=%h busy=%b done=%b exp=all 0", hi, lo, busy, done); end
    saw = 1'b0;
    repeat (40) begin tick(); if (done) saw = 1'b1; end
    checks++; if (saw) begin failures++; $display("FAIL reset_discard saw_done=1 exp=0"); end
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    tick();
    cyc = 1;
    while (!done && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc != 33 || hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL start_held_in_calc cyc=%0d got=%h_%h exp=33 00000002_0000000e", cyc, hi, lo); end
    a = 32'd50; b = 32'd3;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL start_in_fin busy=%b done=%b exp=1,0", busy, done); end
    cyc = 1;
    while (!done && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc != 33 || hi !== 32'd2 || lo !== 32'd16) begin
      failures++; $display("FAIL back_to_back cyc=%0d got=%h_%h exp=33 00000002_00000010", cyc, hi, lo); end
  endtask

  task automatic test_sweep8();
    logic [7:0]  va, vb, eh, el;
    logic [2:0]  o;
    logic [15:0] p;
    int sa, sb, q, r, cyc;
    for (int i = 0; i < 24; i++) begin
      o  = 3'($urandom_range(0, 3));
      va = 8'($urandom);
      vb = 8'($urandom);
      if (i % 6 == 0) vb = 8'h00;
      if (i == 5) begin o = OP_DIV; va = 8'h80; vb = 8'hFF; end
      eh = 8'h0; el = 8'h0; p = 16'h0;
      case (o)
        OP_MULT: begin
          p = {{8{va[7]}}, va} * {{8{vb[7]}}, vb};
          {eh, el} = p;
        end
        OP_MULTU: begin
          p = {8'h00, va} * {8'h00, vb};
          {eh, el} = p;
        end
        OP_DIVU: begin
          if (vb == 8'h00) begin eh = va; el = 8'hFF; end
          else begin el = va / vb; eh = va % vb; end
        end
        default: begin
          if (vb == 8'h00) begin eh = va; el = 8'hFF; end
          else if (va == 8'h80 && vb == 8'hFF) begin eh = 8'h00; el = 8'h80; end
          else begin
            sa = $signed(va); sb = $signed(vb);
            q = sa / sb; r = sa % sb;
            el = q[7:0]; eh = r[7:0];
          end
        end
      endcase
      start8 = 1'b1; op8 = o; a8 = va; b8 = vb;
      tick();
      start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 40) begin tick(); cyc++; end
      checks++; if (cyc != 9 || hi8 !== eh || lo8 !== el) begin
        failures++;
        $display("FAIL sweep8_%0d op=%0d a=%h b=%h got cyc=%0d hi=%h lo=%h exp cyc=9 hi=%h lo=%h",
                 i, o, va, vb, cyc, hi8, lo8, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_mt();
    test_cancel();
    test_illegal();
    test_back_to_back();
    test_sweep8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
